// File: rtl/inc_pulse_gen.sv
// inc_pulse_gen: push-button conditioner for the counter stage.
// Sync, debounce press/release, and optional auto-repeat pulses.
module inc_pulse_gen #(
  parameter int DB_CYCLES  = 1000,
  parameter int RPT_DELAY  = 50000,
  parameter int RPT_PERIOD = 10000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic inc,
  output logic btn_level,
  output logic rpt_active
);

  localparam int MAX_AB =
    (DB_CYCLES > RPT_DELAY) ? DB_CYCLES : RPT_DELAY;
  localparam int MAXV =
    (MAX_AB > RPT_PERIOD) ? MAX_AB : RPT_PERIOD;
  localparam int CW = $clog2(MAXV);

  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(RPT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REPEAT,
    RELEASE_DB
  } state_t;

  logic          meta;
  logic          s;
  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic          inc_n;
  logic          lvl_n;

  // two-flop synchroniser for the asynchronous button level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      s    <= 1'b0;
    end else begin
      meta <= btn_raw;
      s    <= meta;
    end
  end

  // state, shared counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      inc        <= 1'b0;
      btn_level  <= 1'b0;
      rpt_active <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      inc        <= inc_n;
      btn_level  <= lvl_n;
      rpt_active <= (state_n == REPEAT);
    end
  end

  // next-state, counter and pulse decisions; release beats a due pulse
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    inc_n   = 1'b0;
    lvl_n   = btn_level;
    case (state)
      IDLE: begin
        lvl_n = 1'b0;
        if (s) begin
          state_n = PRESS_DB;
          cnt_n   = '0;
        end
      end
      PRESS_DB: begin
        if (!s) begin
          state_n = IDLE;
        end else if (cnt == DB_LAST) begin
          state_n = HELD;
          cnt_n   = '0;
          inc_n   = 1'b1;
          lvl_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_n = RELEASE_DB;
          cnt_n   = '0;
        end else if (!repeat_en) begin
          cnt_n = '0;
        end else if (cnt == DLY_LAST) begin
          state_n = REPEAT;
          cnt_n   = '0;
          inc_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      REPEAT: begin
        if (!s) begin
          state_n = RELEASE_DB;
          cnt_n   = '0;
        end else if (!repeat_en) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == PER_LAST) begin
          cnt_n = '0;
          inc_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      RELEASE_DB: begin
        if (s) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n = IDLE;
          lvl_n   = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_inc_pulse_gen.sv
// tb_inc_pulse_gen: table-driven bench for inc_pulse_gen.
// DB_CYCLES=4, RPT_DELAY=8, RPT_PERIOD=3.
module tb_inc_pulse_gen;

  logic clk;
  logic reset;
  logic btn_raw;
  logic repeat_en;
  logic inc;
  logic btn_level;
  logic rpt_active;

  inc_pulse_gen #(
    .DB_CYCLES (4),
    .RPT_DELAY (8),
    .RPT_PERIOD(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .repeat_en (repeat_en),
    .inc       (inc),
    .btn_level (btn_level),
    .rpt_active(rpt_active)
  );

  typedef struct {
    logic       rst;
    logic       btn;
    logic       ren;
    logic [2:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [2:0] sb_q[$];
  int         checks;
  int         errors;
  int         idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic void add(input logic rst, input logic btn,
                              input logic ren, input logic e_inc,
                              input logic e_lvl, input logic e_rpt);
    vec_t v;
    v.rst = rst;
    v.btn = btn;
    v.ren = ren;
    v.exp = {e_inc, e_lvl, e_rpt};
    tbl.push_back(v);
  endfunction

  task automatic check3(input string name, input logic [2:0] got,
                        input logic [2:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inc/lvl/rpt got %b want %b", name, got, want);
    end
  endtask

  task automatic apply(input vec_t v);
    logic [2:0] want;
    @(negedge clk);
    reset     = v.rst;
    btn_raw   = v.btn;
    repeat_en = v.ren;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    want = sb_q.pop_front();
    idx++;
    check3($sformatf("vec%0d", idx),
           {inc, btn_level, rpt_active}, want);
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    idx       = 0;
    reset     = 1'b0;
    btn_raw   = 1'b0;
    repeat_en = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check3("reset_state", {inc, btn_level, rpt_active}, 3'b000);

    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    // clean press, no repeat: single pulse at edge 7
    for (int e = 1; e <= 30; e++)
      add(0, 1, 0, e == 7, e >= 7, 0);
    // release with a one-cycle glitch; level drops at edge 10
    for (int r = 1; r <= 15; r++)
      add(0, r == 3, 0, 0, r < 10, 0);
    add(1, 0, 0, 0, 0, 0);
    // short bounce never qualifies
    for (int e = 1; e <= 12; e++)
      add(0, e <= 2, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    // auto-repeat, then repeat_en off for 26..35, back on at 36
    for (int e = 1; e <= 49; e++)
      add(0, 1, !(e >= 26 && e <= 35),
          (e == 7) || (e == 15) || (e == 18) || (e == 21) ||
          (e == 24) || (e == 43) || (e == 46) || (e == 49),
          e >= 7,
          (e >= 15 && e <= 25) || (e >= 43));
    run_table();

    // async reset while the repeat pulse is high
    check3("pre_reset_pulse", {inc, btn_level, rpt_active}, 3'b111);
    #2;
    reset = 1'b1;
    #1;
    check3("async_reset", {inc, btn_level, rpt_active}, 3'b000);

    // button still held: press requalified from scratch
    add(1, 1, 1, 0, 0, 0);
    for (int e = 1; e <= 10; e++)
      add(0, 1, 1, e == 7, e >= 7, 0);
    run_table();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
